// File: rtl/axis_host_endpoint.sv
// Host-side AXI-Stream endpoint: streams a preloaded frame out, then captures the returned frame.
// Latency: first tx beat two cycles after an accepted start; capture read data one cycle after cap_addr.
// Backpressure: tx words are held stable while tready is low; s_axis_tready is only high in RX.
module axis_host_endpoint #(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 20,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [ADDR_W:0]      tx_len,
  input  logic                 load_we,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [PAYLOAD_W-1:0] load_data,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic [ADDR_W-1:0]    cap_addr,
  output logic [PAYLOAD_W-1:0] cap_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      rx_count,
  output logic                 err_overflow
);

  typedef enum logic [2:0] {IDLE, PREFETCH, TX, RX, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t               state;
  logic [PAYLOAD_W-1:0] tx_mem  [DEPTH];
  logic [PAYLOAD_W-1:0] cap_mem [DEPTH];
  logic [PAYLOAD_W-1:0] tx_rd;
  logic [ADDR_W:0]      len;
  logic [ADDR_W-1:0]    tx_idx;
  logic [ADDR_W:0]      next_idx;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 tx_hs;
  logic                 rx_hs;
  logic                 start_ok;
  logic                 unused_tdata_hi;

  assign tx_hs    = m_axis_tvalid & m_axis_tready;
  assign rx_hs    = s_axis_tvalid & s_axis_tready;
  assign start_ok = start && (tx_len != '0) && (tx_len <= DEPTH_L);
  assign next_idx = {1'b0, tx_idx} + ONE_L;
  // Look one word ahead on a handshake so the next beat follows with no bubble;
  // while stalled the current word is simply re-read (memory is frozen outside IDLE).
  assign rd_addr  = tx_hs ? next_idx[ADDR_W-1:0] : tx_idx;

  // Payload is zero-extended onto the bus; bus is quiet whenever nothing is offered.
  assign m_axis_tdata = m_axis_tvalid ? {{(DATA_W-PAYLOAD_W){1'b0}}, tx_rd} : '0;

  // Result bits above the payload are intentionally discarded.
  assign unused_tdata_hi = &{1'b0, s_axis_tdata[DATA_W-1:PAYLOAD_W]};

  // Tx memory: host loads only while idle; synchronous read feeds the stream.
  always_ff @(posedge aclk) begin
    if (state == IDLE && load_we) tx_mem[load_addr] <= load_data;
    tx_rd <= tx_mem[rd_addr];
  end

  // Capture memory: write accepted results below DEPTH; read port returns old data on collision.
  always_ff @(posedge aclk) begin
    if (rx_hs && rx_count != DEPTH_L) cap_mem[rx_count[ADDR_W-1:0]] <= s_axis_tdata[PAYLOAD_W-1:0];
    cap_data <= cap_mem[cap_addr];
  end

  // Transaction sequencer with registered stream handshakes and status outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rx_count      <= '0;
      err_overflow  <= 1'b0;
      len           <= '0;
      tx_idx        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            len          <= tx_len;
            rx_count     <= '0;
            err_overflow <= 1'b0;
            tx_idx       <= '0;
            busy         <= 1'b1;
            state        <= PREFETCH;
          end
        end
        PREFETCH: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= (len == ONE_L);
          state         <= TX;
        end
        TX: begin
          if (tx_hs) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              s_axis_tready <= 1'b1;
              state         <= RX;
            end else begin
              tx_idx       <= next_idx[ADDR_W-1:0];
              m_axis_tlast <= (next_idx == len - ONE_L);
            end
          end
        end
        RX: begin
          if (rx_hs) begin
            if (rx_count == DEPTH_L) err_overflow <= 1'b1;
            else                     rx_count     <= rx_count + ONE_L;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_host_endpoint.sv
// Directed bench for axis_host_endpoint: tx framing, stalls, capture, overflow, reset and ignored starts.
module tb_axis_host_endpoint;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic [10:0] tx_len;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [19:0] load_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [9:0]  cap_addr;
  logic [19:0] cap_data;
  logic        busy;
  logic        done;
  logic [10:0] rx_count;
  logic        err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_mem [1024];

  axis_host_endpoint dut (
    .aclk(aclk), .areset(areset), .start(start), .tx_len(tx_len),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .cap_addr(cap_addr), .cap_data(cap_data), .busy(busy), .done(done),
    .rx_count(rx_count), .err_overflow(err_overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [19:0] data);
    @(negedge aclk);
    load_we = 1'b1; load_addr = addr[9:0]; load_data = data;
    exp_mem[addr] = data;
    @(negedge aclk);
    load_we = 1'b0;
  endtask

  task automatic do_start(input int len);
    @(negedge aclk);
    start = 1'b1; tx_len = len[10:0];
    @(negedge aclk);
    start = 1'b0;
  endtask

  // Collect the tx frame; toggle applies a 1,0,0,1 tready pattern, early drives results during TX.
  task automatic tx_frame(input int len, input bit toggle, input bit early);
    int k = 0;
    int cyc = 0;
    int first_c = 0;
    int last_c = 0;
    bit stalled = 0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    logic [3:0] pat = 4'b1001;
    if (early) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD0000; s_axis_tlast = 1'b1;
    end
    while (k < len && cyc < 100) begin
      @(negedge aclk);
      m_axis_tready = toggle ? pat[cyc % 4] : 1'b1;
      if (m_axis_tvalid) begin
        check("tx_busy", {31'd0, busy}, 32'd1);
        check("tx_s_rdy", {31'd0, s_axis_tready}, 32'd0);
        if (stalled) begin
          check("stall_dat", m_axis_tdata, pd);
          check("stall_last", {31'd0, m_axis_tlast}, {31'd0, pl});
        end
        if (m_axis_tready) begin
          check("tx_dat", m_axis_tdata, {12'h000, exp_mem[k]});
          check("tx_last", {31'd0, m_axis_tlast}, {31'd0, (k == len - 1)});
          if (k == 0) first_c = cyc;
          last_c = cyc;
          k++;
          stalled = 0;
        end else begin
          stalled = 1; pd = m_axis_tdata; pl = m_axis_tlast;
        end
      end
      cyc++;
    end
    check("tx_beats", k, len);
    if (!toggle) check("tx_gap", last_c - first_c, len - 1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check("tx_end_vld", {31'd0, m_axis_tvalid}, 32'd0);
    check("tx_end_last", {31'd0, m_axis_tlast}, 32'd0);
    check("rx_rdy0", {31'd0, s_axis_tready}, 32'd1);
    check("rx_cnt0", {21'd0, rx_count}, 32'd0);
  endtask

  task automatic rx_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = base + i; s_axis_tlast = (i == n - 1);
      check("rx_rdy", {31'd0, s_axis_tready}, 32'd1);
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("rx_rdy_off", {31'd0, s_axis_tready}, 32'd0);
    check("rx_busy_off", {31'd0, busy}, 32'd0);
    @(negedge aclk);
    check("done_once", {31'd0, done}, 32'd0);
  endtask

  task automatic read_cap(input int addr, input logic [19:0] exp);
    @(negedge aclk);
    cap_addr = addr[9:0];
    @(negedge aclk);
    check("cap_data", {12'h000, cap_data}, {12'h000, exp});
  endtask

  task automatic expect_quiet(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check(tag, {30'd0, busy, m_axis_tvalid}, 32'd0);
    end
  endtask

  initial begin
    int k;
    areset = 1'b1; start = 1'b0; tx_len = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; cap_addr = '0;
    repeat (2) @(negedge aclk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_s_rdy", {31'd0, s_axis_tready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rx_count", {21'd0, rx_count}, 32'd0);
    check("rst_ovf", {31'd0, err_overflow}, 32'd0);
    areset = 1'b0;

    for (int i = 0; i < 8; i++) load_word(i, 20'(i + 1));

    // Full-rate frame of eight words.
    do_start(8);
    tx_frame(8, 0, 0);
    rx_frame(8, 32'h11100000);
    check("rx_count8a", {21'd0, rx_count}, 32'd8);

    // Stalled frame with results offered early, then capture readback.
    do_start(8);
    tx_frame(8, 1, 1);
    rx_frame(8, 32'hABC00000);
    check("rx_count8b", {21'd0, rx_count}, 32'd8);
    check("ovf_none", {31'd0, err_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) read_cap(i, 20'(i));

    // Single-word frame followed by an overflowing result stream.
    do_start(1);
    tx_frame(1, 0, 0);
    rx_frame(1025, 32'h12300000);
    check("ovf_set", {31'd0, err_overflow}, 32'd1);
    check("ovf_count", {21'd0, rx_count}, 32'd1024);
    read_cap(1023, 20'h003FF);
    read_cap(0, 20'h00000);

    // A fresh start clears the sticky overflow and the count.
    do_start(2);
    check("ovf_clear", {31'd0, err_overflow}, 32'd0);
    check("cnt_clear", {21'd0, rx_count}, 32'd0);
    tx_frame(2, 0, 0);
    rx_frame(2, 32'h00000000);

    // Reset while the fourth beat is on the bus.
    do_start(8);
    m_axis_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        if (k == 3) break;
        k++;
      end
    end
    check("rst_mid_beat", k, 3);
    areset = 1'b1;
    #1;
    check("rst_mid_vld", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_last", {31'd0, m_axis_tlast}, 32'd0);
    @(negedge aclk);
    check("rst_mid_vld2", {31'd0, m_axis_tvalid}, 32'd0);
    areset = 1'b0;

    do_start(3);
    tx_frame(3, 0, 0);
    rx_frame(3, 32'h55500000);
    check("rx_count3", {21'd0, rx_count}, 32'd3);
    read_cap(2, 20'h00002);

    // Out-of-range lengths are ignored.
    do_start(0);
    expect_quiet("len0_quiet");
    do_start(1025);
    expect_quiet("len1025_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_host_endpoint.md
Name: axis_host_endpoint

Overview:
- On-chip host-side AXI-Stream endpoint. It is the opposite end of the accelerator DMA stream interface.
- Transmits a preloaded frame of samples as AXIS master into the accelerator's slave port, then captures the returned frame from the accelerator's master port into a capture memory.
- Used for self-test and for loopback bring-up without the PS/DMA path; replaces the host-side stream during standalone runs.

Parameters:
- DATA_W, 32, AXIS tdata width.
- PAYLOAD_W, 20, sample width stored in memories; zero-extended on tx, truncated on rx.
- ADDR_W, 10, address width of tx and capture memories.
- DEPTH, 1024, words per memory (2**ADDR_W).

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a transaction when in IDLE.
- tx_len  in  ADDR_W+1  frame length in words, 1..DEPTH; sampled on accepted start.
- load_we  in  1  tx memory write enable.
- load_addr  in  ADDR_W  tx memory write address.
- load_data  in  PAYLOAD_W  tx memory write data.
- m_axis_tdata  out  DATA_W  sample to accelerator, {zeros, payload}.
- m_axis_tvalid  out  1  master valid.
- m_axis_tlast  out  1  last word of frame.
- m_axis_tready  in  1  accelerator ready.
- s_axis_tdata  in  DATA_W  result from accelerator.
- s_axis_tvalid  in  1  result valid.
- s_axis_tlast  in  1  last result word.
- s_axis_tready  out  1  endpoint ready.
- cap_addr  in  ADDR_W  capture memory read address.
- cap_data  out  PAYLOAD_W  capture read data; one-cycle latency.
- busy  out  1  high in TX or RX.
- done  out  1  one-cycle pulse when the frame is captured.
- rx_count  out  ADDR_W+1  words captured in the last or current frame.
- err_overflow  out  1  sticky; set if more than DEPTH words are received.

Behaviour:
- Reset (async, active-high) values:
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, busy=0, done=0, rx_count=0, err_overflow=0.
  - State: FSM=IDLE.
  - Memory contents are not reset and are retained.
- FSM states: IDLE, PREFETCH, TX, RX, DONE.
- IDLE:
  - load_we writes tx memory. load_we is ignored in every other state.
  - start with tx_len in 1..DEPTH: latch tx_len, clear rx_count and err_overflow, rd_ptr=0, go to PREFETCH.
  - start with tx_len=0 or tx_len>DEPTH is ignored.
- PREFETCH:
  - One cycle covering the synchronous memory read of word 0.
  - Next state is TX with m_axis_tvalid=1 and word 0 on tdata.
- TX:
  - tdata, tvalid and tlast are held stable while tvalid=1 and tready=0.
  - On a handshake the next word is presented the following cycle with no bubble. The memory read address is advanced combinationally from the handshake so the next word is ready in time.
  - m_axis_tlast=1 exactly on word index tx_len-1. tx_len=1 gives tlast on the first word.
  - After the tlast handshake: tvalid=0, tlast=0, go to RX.
  - Throughput is 1 word/cycle when tready is held high.
- RX:
  - s_axis_tready=1.
  - Each handshake writes s_axis_tdata[PAYLOAD_W-1:0] to capture[rx_count] if rx_count<DEPTH, then rx_count++.
  - When rx_count==DEPTH, further words are dropped, err_overflow is set, tready stays 1 to drain, and rx_count saturates at DEPTH.
  - On the handshake with s_axis_tlast=1: tready=0 next cycle, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in PREFETCH, TX and RX.
- Stream input handling:
  - s_axis_tready=0 outside RX, so results arriving early are back-pressured, not lost.
  - start is ignored outside IDLE.
- Capture read port:
  - Available in all states.
  - A read and write to the same address in the same cycle returns the old data.
- Reset asserted mid-frame: immediate return to IDLE with reset outputs. No partial tlast is emitted.

Test Plan:
- Load 0x00001..0x00008, start with tx_len=8, m_axis_tready=1 -> eight consecutive beats with tdata=0x00000001..0x00000008, tlast only on beat 8, busy=1.
- Same frame with m_axis_tready toggling 1,0,0,1 -> no word is duplicated or skipped, and tdata/tlast are stable while stalled.
- After TX, drive 8 result words 0xABC00000+i with tlast on the 8th -> done pulses once, rx_count=8, and cap_data at addr i reads 0x00000+i (low 20 bits of 0xABC00000+i) one cycle after cap_addr=i.
- Drive s_axis_tvalid during TX -> s_axis_tready=0 and nothing is captured until RX.
- tx_len=1 -> a single beat with tlast=1. Send 1025 results with DEPTH=1024 -> err_overflow=1 and rx_count=1024.
- Assert areset mid-TX at beat 4 -> next edge has tvalid=0 and busy=0; a new start with tx_len=3 then runs cleanly. tx_len=0 start -> no activity.
